cordic_vectoring: RTL and testbench

//   Inverse of the rotation-mode CORDIC. Vectoring-mode iterative CORDIC.

---
 rtl/cordic_pkg.sv | 27 ++
 rtl/cordic_vectoring_if.sv | 13 +
 rtl/cordic_atan_rom.sv | 13 +
 rtl/cordic_vectoring.sv | 159 +++++++++++++++
 tb/tb_cordic_vectoring.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants (Q.16 angles, inverse gain), arctangent table and FSM state type.
// Used by both the rotation and vectoring cores.
package cordic_pkg;

   localparam int HALF_PI  = 102944;
   localparam int PI       = 205887;
   localparam int INV_GAIN = 39797;

   localparam int ATAN_W = 17;

   // atan(2^-i) * 2^16, rounded to nearest
   localparam logic [ATAN_W-1:0] ATAN_TBL [16] = '{
      17'd51472, 17'd30386, 17'd16055, 17'd8150,
      17'd4091,  17'd2047,  17'd1024,  17'd512,
      17'd256,   17'd128,   17'd64,    17'd32,
      17'd16,    17'd8,     17'd4,     17'd2
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ROT,
      ST_GAIN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/cordic_vectoring_if.sv
// Start/complete handshake and data bus of the vectoring-mode CORDIC.
interface cordic_vectoring_if #(parameter int DW = 18);
   logic signed [DW-1:0] x_in;
   logic signed [DW-1:0] y_in;
   logic                 init;
   logic signed [DW:0]   angle;
   logic [DW+1:0]        magnitude;
   logic                 busy;
   logic                 done;

   modport master (output x_in, y_in, init, input angle, magnitude, busy, done);
   modport slave  (input x_in, y_in, init, output angle, magnitude, busy, done);
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index -> atan(2^-i) in Q.16.
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int IDXW = 4
) (
   input  logic [IDXW-1:0]   idx,
   output logic [ATAN_W-1:0] atan
);

   assign atan = ATAN_TBL[idx];

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2(y, x) and vector length.
// Optional CORDIC_GAIN_COMP_EN adds a GAIN cycle that removes the CORDIC gain from magnitude.
//
// state | meaning
// IDLE  | waiting for init; inputs latched on acceptance
// LOAD  | sign-extend, pre-rotate left half plane, latch zero-vector flag
// ROT   | one micro-rotation per cycle, i = 0..ITER-1
// GAIN  | magnitude scaled by INV_GAIN (CORDIC_GAIN_COMP_EN only)
// DONE  | publish results, pulse done, drop busy
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int DW   = 18,
   parameter int FRAC = 16,
   parameter int ITER = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   cordic_vectoring_if.slave  bus
);

   localparam int IW = DW + 2;
   localparam int CW = $clog2(FRAC);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   state_e               state_q, state_d;
   logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic [CW-1:0]        i_q, i_d;
   logic                 zero_q, zero_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic signed [DW:0]   angle_q, angle_d;
   logic [IW-1:0]        mag_q, mag_d;

   logic [ATAN_W-1:0]    atan_w;
   logic signed [IW-1:0] atan_ext;

   cordic_atan_rom #(.IDXW(CW)) u_atan_rom (
      .idx  (i_q),
      .atan (atan_w)
   );

   assign atan_ext = {{(IW-ATAN_W){1'b0}}, atan_w};

`ifdef CORDIC_GAIN_COMP_EN
   localparam logic signed [16:0] INV_GAIN_S = 17'(INV_GAIN);
   logic signed [IW+16:0] prod;
   assign prod = x_q * INV_GAIN_S;
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      zero_d  = zero_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      angle_d = angle_q;
      mag_d   = mag_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.init) begin
               x_d     = {{2{bus.x_in[DW-1]}}, bus.x_in};
               y_d     = {{2{bus.y_in[DW-1]}}, bus.y_in};
               busy_d  = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            zero_d  = (x_q == '0) && (y_q == '0);
            i_d     = '0;
            z_d     = '0;
            state_d = ST_ROT;
            // Left half plane is turned by -/+90 deg so the iterations always converge
            if (x_q[IW-1]) begin
               if (!y_q[IW-1]) begin
                  x_d = y_q;
                  y_d = -x_q;
                  z_d = IW'(HALF_PI);
               end else begin
                  x_d = -y_q;
                  y_d = x_q;
                  z_d = IW'(-HALF_PI);
               end
            end
         end
         ST_ROT: begin
            if (!y_q[IW-1]) begin
               x_d = x_q + (y_q >>> i_q);
               y_d = y_q - (x_q >>> i_q);
               z_d = z_q + atan_ext;
            end else begin
               x_d = x_q - (y_q >>> i_q);
               y_d = y_q + (x_q >>> i_q);
               z_d = z_q - atan_ext;
            end
            i_d = i_q + CW'(1);
            if (i_q == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
               state_d = ST_GAIN;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef CORDIC_GAIN_COMP_EN
         ST_GAIN: begin
            x_d     = IW'(prod >>> FRAC);
            state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            angle_d = zero_q ? '0 : z_q[DW:0];
            mag_d   = zero_q ? '0 : x_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         angle_q <= '0;
         mag_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         angle_q <= angle_d;
         mag_q   <= mag_d;
      end
   end

   assign bus.angle     = angle_q;
   assign bus.magnitude = mag_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: spec vectors, corner sequences, round trip, random.
// Reference is real-valued atan2/sqrt scaled to Q.16.
module tb_cordic_vectoring;

   localparam int DW    = 18;
   localparam int FRAC  = 16;
   localparam int ITER  = 16;
   localparam int PI_Q  = 205887;
   localparam int TWO_PI_Q = 411775;
   localparam int ATOL  = 8;
   localparam int MTOL  = ITER;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int LAT  = ITER + 3;
   localparam bit COMP = 1'b1;
`else
   localparam int LAT  = ITER + 2;
   localparam bit COMP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   cordic_vectoring_if #(.DW(DW)) bus ();

   cordic_vectoring #(.DW(DW), .FRAC(FRAC), .ITER(ITER)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int x;
      int y;
      int ang;
   } vec_t;

   task automatic check(input string name, input int act, input int exp, input int tol);
      int d;
      checks++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d tol=%0d", name, act, exp, tol);
      end
   endtask

   task automatic check_angle(input string name, input int act, input int exp);
      int d;
      checks++;
      d = act - exp;
      if (d > PI_Q)  d -= TWO_PI_Q;
      if (d < -PI_Q) d += TWO_PI_Q;
      if (d < 0) d = -d;
      if (d > ATOL) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d tol=%0d", name, act, exp, ATOL);
      end
   endtask

   function automatic real cordic_k();
      real k = 1.0;
      for (int i = 0; i < ITER; i++) k = k * $sqrt(1.0 + 1.0 / (4.0 ** i));
      return k;
   endfunction

   function automatic int model_angle(input int x, input int y);
      if (x == 0 && y == 0) return 0;
      return int'($atan2(real'(y), real'(x)) * 65536.0);
   endfunction

   function automatic int model_mag(input int x, input int y);
      real len;
      len = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      if (COMP) return int'(len);
      return int'(len * cordic_k());
   endfunction

   // Presents one vector with an init pulse, then waits (bounded) for done.
   task automatic run_vec(input int x, input int y, output int ang, output int mag,
                          output int lat, output int busy_start, output int busy_done);
      @(negedge clk);
      bus.x_in = DW'(x);
      bus.y_in = DW'(y);
      bus.init = 1'b1;
      @(posedge clk);
      #1;
      bus.init   = 1'b0;
      busy_start = int'(bus.busy);
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = c;
            break;
         end
      end
      ang       = $signed(bus.angle);
      mag       = int'(bus.magnitude);
      busy_done = int'(bus.busy);
   endtask

   initial begin
      vec_t tbl[6];
      real  rt_ang[4];
      int   ang, mag, lat, bs, bd, x, y, seen;

      tbl[0] = '{x: 23745,  y: 61081, ang: 78643};
      tbl[1] = '{x: 65536,  y: 0,     ang: 0};
      tbl[2] = '{x: 0,      y: 65536, ang: 102944};
      tbl[3] = '{x: -65536, y: 0,     ang: 205887};
      tbl[4] = '{x: -65536, y: -1,    ang: -205887};
      tbl[5] = '{x: 0,      y: 0,     ang: 0};
      rt_ang = '{-1.5, -0.5, 0.3, 1.2};

      rst_n    = 1'b0;
      bus.init = 1'b0;
      bus.x_in = '0;
      bus.y_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_angle", $signed(bus.angle), 0, 0);
      check("reset_mag",   int'(bus.magnitude), 0, 0);
      check("reset_busy",  int'(bus.busy), 0, 0);
      check("reset_done",  int'(bus.done), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) begin
         run_vec(tbl[t].x, tbl[t].y, ang, mag, lat, bs, bd);
         check_angle($sformatf("tbl%0d_angle", t), ang, tbl[t].ang);
         if (tbl[t].x == 0 && tbl[t].y == 0)
            check($sformatf("tbl%0d_mag", t), mag, 0, 0);
         else
            check($sformatf("tbl%0d_mag", t), mag, model_mag(tbl[t].x, tbl[t].y), MTOL);
         check($sformatf("tbl%0d_latency", t), lat, LAT, 0);
         check($sformatf("tbl%0d_busy_start", t), bs, 1, 0);
         check($sformatf("tbl%0d_busy_at_done", t), bd, 0, 0);
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_done_one_cycle", t), int'(bus.done), 0, 0);
         check($sformatf("tbl%0d_angle_hold", t), $signed(bus.angle), ang, 0);
      end

      // init re-pulsed at edge N+5 with another vector must be ignored
      @(negedge clk);
      bus.x_in = DW'(23745);
      bus.y_in = DW'(61081);
      bus.init = 1'b1;
      @(posedge clk);
      #1;
      bus.init = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.x_in = DW'(-40000);
      bus.y_in = DW'(-50000);
      bus.init = 1'b1;
      @(posedge clk);
      #1;
      bus.init = 1'b0;
      lat = -1;
      for (int c = 6; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = c;
            break;
         end
      end
      check("repulse_latency", lat, LAT, 0);
      check_angle("repulse_angle", $signed(bus.angle), 78643);
      check("repulse_mag", int'(bus.magnitude), model_mag(23745, 61081), MTOL);

      // reset at edge N+8 aborts; no done follows
      @(negedge clk);
      bus.x_in = DW'(50000);
      bus.y_in = DW'(-30000);
      bus.init = 1'b1;
      @(posedge clk);
      #1;
      bus.init = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_angle", $signed(bus.angle), 0, 0);
      check("abort_mag",   int'(bus.magnitude), 0, 0);
      check("abort_busy",  int'(bus.busy), 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < LAT + 5; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) seen = 1;
      end
      check("abort_no_done", seen, 0, 0);
      run_vec(50000, -30000, ang, mag, lat, bs, bd);
      check_angle("after_abort_angle", ang, model_angle(50000, -30000));
      check("after_abort_mag", mag, model_mag(50000, -30000), MTOL);
      check("after_abort_latency", lat, LAT, 0);

      // round trip from cosine/sine pairs
      for (int k = 0; k < 4; k++) begin
         x = int'($cos(rt_ang[k]) * 65536.0);
         y = int'($sin(rt_ang[k]) * 65536.0);
         run_vec(x, y, ang, mag, lat, bs, bd);
         check_angle($sformatf("roundtrip%0d_angle", k), ang, int'(rt_ang[k] * 65536.0));
         check($sformatf("roundtrip%0d_mag", k), mag, model_mag(x, y), MTOL);
      end

      // random vectors with length >= 1.0, issued back-to-back
      for (int r = 0; r < 40; r++) begin
         x = 65536;
         y = 0;
         for (int tries = 0; tries < 100; tries++) begin
            x = int'($urandom_range(262143, 0)) - 131072;
            y = int'($urandom_range(262143, 0)) - 131072;
            if (real'(x) * real'(x) + real'(y) * real'(y) >= 65536.0 * 65536.0) break;
         end
         run_vec(x, y, ang, mag, lat, bs, bd);
         check_angle($sformatf("rand%0d_angle x=%0d y=%0d", r, x, y), ang, model_angle(x, y));
         check($sformatf("rand%0d_mag x=%0d y=%0d", r, x, y), mag, model_mag(x, y), MTOL);
         check($sformatf("rand%0d_latency", r), lat, LAT, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
